// File: rtl/seq_alu_mdu_pkg.sv
// Shared op codes, FSM states and op classification for the execute-stage ALU/MDU.
// Build option: MDU_DIV_EN includes DIV/DIVU in the multi-cycle op class.
package seq_alu_mdu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [OP_W-1:0] ALU_ADDU  = 4'd1;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'd2;
  localparam logic [OP_W-1:0] ALU_SUBU  = 4'd3;
  localparam logic [OP_W-1:0] ALU_AND   = 4'd4;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'd7;
  localparam logic [OP_W-1:0] ALU_LUI   = 4'd8;
  localparam logic [OP_W-1:0] ALU_MULT  = 4'd9;
  localparam logic [OP_W-1:0] ALU_MULTU = 4'd10;
  localparam logic [OP_W-1:0] ALU_DIV   = 4'd11;
  localparam logic [OP_W-1:0] ALU_DIVU  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Ops that go through the iterative unit instead of the single-cycle path
  function automatic logic alu_is_mdu(input logic [OP_W-1:0] op);
`ifdef MDU_DIV_EN
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
`else
    return (op == ALU_MULT) || (op == ALU_MULTU);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with sign fix-up.
// Build option: MDU_DIV_EN keeps the divide datapath; otherwise only multiply remains.
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             fin
);
  localparam int unsigned     PW   = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
  logic             neg_q_q;
  logic [WIDTH-1:0] a_mag, b_mag, acc_d, mq_d;
  logic [WIDTH:0]   sum;
`ifdef MDU_DIV_EN
  logic             div_q, div0_q, neg_r_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH:0]   trial;
`else
  logic             unused_is_div;
  assign unused_is_div = is_div;
`endif

  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
  assign fin   = run_q && (cnt_q == LAST);

  // One iteration: acc/mq form {hi,lo} of the product, or {remainder,quotient}
  always_comb begin
    sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    acc_d = sum[WIDTH:1];
    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    trial = {acc_q, mq_q[WIDTH-1]} - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_d = trial[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Final step is presented combinationally so the top can latch it on the last ITER edge
  always_comb begin
    hi = acc_d;
    lo = mq_d;
`ifdef MDU_DIV_EN
    if (div_q) begin
      if (div0_q) begin
        hi = a_raw_q;
        lo = '1;
      end else begin
        if (neg_q_q) lo = (~mq_d) + WIDTH'(1);
        if (neg_r_q) hi = (~acc_d) + WIDTH'(1);
      end
    end else if (neg_q_q) begin
      {hi, lo} = (~{acc_d, mq_d}) + PW'(1);
    end
`else
    if (neg_q_q) {hi, lo} = (~{acc_d, mq_d}) + PW'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      neg_q_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
      neg_r_q <= 1'b0;
      a_raw_q <= '0;
`endif
    end else if (go) begin
      run_q   <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= a_mag;
      opnd_q  <= b_mag;
      neg_q_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
      div_q   <= is_div;
      div0_q  <= is_div && (b == '0);
      neg_r_q <= is_signed && a[WIDTH-1];
      a_raw_q <= a;
`endif
    end else if (run_q) begin
      if (fin) begin
        run_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu_mdu.sv
// Execute-stage ALU with registered results and a start/busy/done handshake to the MDU.
// Build option: MDU_DIV_EN enables DIV/DIVU; without it they finish in one cycle flagging div0_o.
module seq_alu_mdu
  import seq_alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int unsigned HALF_W = WIDTH / 2;

  state_e           state_q, state_d;
  logic             busy_d, done_d, zero_d, ovf_d, div0_d;
  logic [WIDTH-1:0] result_d, hi_d, lo_d;
  logic [WIDTH-1:0] sum_c, diff_c, sc_res_c;
  logic             sc_ovf_c, is_div_c, is_signed_c, unsup_c, mdu_go_c;
  logic             div0_pend_q;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  logic             mdu_fin;

  assign sum_c       = a_i + b_i;
  assign diff_c      = a_i - b_i;
  assign is_div_c    = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
  assign is_signed_c = (op_i == ALU_MULT) || (op_i == ALU_DIV);
`ifdef MDU_DIV_EN
  assign unsup_c     = 1'b0;
`else
  assign unsup_c     = is_div_c;
`endif

  // Single-cycle result and overflow
  always_comb begin
    sc_res_c = '0;
    sc_ovf_c = 1'b0;
    case (op_i)
      ALU_ADD: begin
        sc_res_c = sum_c;
        sc_ovf_c = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_ADDU: sc_res_c = sum_c;
      ALU_SUB: begin
        sc_res_c = diff_c;
        sc_ovf_c = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUBU: sc_res_c = diff_c;
      ALU_AND:  sc_res_c = a_i & b_i;
      ALU_OR:   sc_res_c = a_i | b_i;
      ALU_SLT:  sc_res_c = WIDTH'($signed(a_i) < $signed(b_i));
      ALU_SLTU: sc_res_c = WIDTH'(a_i < b_i);
      ALU_LUI:  sc_res_c = {b_i[HALF_W-1:0], {HALF_W{1'b0}}};
      default:  sc_res_c = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_o;
    done_d   = 1'b0;
    result_d = result_o;
    zero_d   = zero_o;
    ovf_d    = ovf_o;
    div0_d   = div0_o;
    hi_d     = hi_o;
    lo_d     = lo_o;
    mdu_go_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          if (alu_is_mdu(op_i)) begin
            mdu_go_c = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_ITER;
          end else begin
            state_d = ST_EXEC;
            done_d  = 1'b1;
            if (unsup_c) begin
              div0_d = 1'b1;
            end else begin
              result_d = sc_res_c;
              zero_d   = (sc_res_c == '0);
              ovf_d    = sc_ovf_c;
            end
          end
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_ITER: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (mdu_fin) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = mdu_hi;
          lo_d    = mdu_lo;
          div0_d  = div0_pend_q;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      ovf_o       <= 1'b0;
      div0_o      <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
      div0_pend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      result_o <= result_d;
      zero_o   <= zero_d;
      ovf_o    <= ovf_d;
      div0_o   <= div0_d;
      hi_o     <= hi_d;
      lo_o     <= lo_d;
      if (mdu_go_c) div0_pend_q <= is_div_c && (b_i == '0);
    end
  end

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (mdu_go_c),
    .is_div    (is_div_c),
    .is_signed (is_signed_c),
    .a         (a_i),
    .b         (b_i),
    .hi        (mdu_hi),
    .lo        (mdu_lo),
    .fin       (mdu_fin)
  );

endmodule

// File: tb/tb_seq_alu_mdu.sv
// Directed self-checking bench for seq_alu_mdu (WIDTH=32); follows MDU_DIV_EN like the RTL.
module tb_seq_alu_mdu;
  import seq_alu_mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [3:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o, zero_o, ovf_o, div0_o;
  logic [W-1:0] result_o, hi_o, lo_o;

  int           n_tests = 0;
  int           n_fail = 0;
  int           lat;
  int           busy_cnt;
  int           pulses;
  logic [W-1:0] exp_hi, exp_lo;
  logic [3:0]   rst_op;

  always #5 clk = ~clk;

  seq_alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .ovf_o    (ovf_o),
    .div0_o   (div0_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done_o; lat counts cycles after the start cycle
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_result", result_o, 0);
    check_eq("rst_hilo", {hi_o, lo_o}, 0);
    check_eq("rst_flags", {zero_o, ovf_o, div0_o}, 0);
    rst_n = 1'b1;

    run_op(ALU_ADDU, 32'hFFFF_FFFF, 32'h1);
    check_eq("addu_lat", lat, 1);
    check_eq("addu_res", result_o, 0);
    check_eq("addu_zero_ovf", {zero_o, ovf_o}, 2'b10);

    run_op(ALU_LUI, 32'h0, 32'h1234_ABCD);
    check_eq("lui_res", result_o, 32'hABCD_0000);
    run_op(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0);
    check_eq("or_res", result_o, 32'h0F0F_00F0);
    run_op(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check_eq("and_res", result_o, 32'h0F00_0F00);

    run_op(ALU_SLT, 32'hFFFF_FFFE, 32'h1);
    check_eq("slt_res", result_o, 1);
    check_eq("slt_zero", zero_o, 0);
    run_op(ALU_SLTU, 32'hFFFF_FFFE, 32'h1);
    check_eq("sltu_res", result_o, 0);
    check_eq("sltu_zero", zero_o, 1);

    run_op(ALU_SUB, 32'h8000_0000, 32'h1);
    check_eq("sub_res", result_o, 32'h7FFF_FFFF);
    check_eq("sub_ovf", ovf_o, 1);
    run_op(ALU_SUBU, 32'h0, 32'h1);
    check_eq("subu_res", result_o, 32'hFFFF_FFFF);
    check_eq("subu_ovf", ovf_o, 0);

    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    check_eq("add_lat", lat, 1);
    check_eq("add_busy", busy_cnt, 0);
    check_eq("add_res", result_o, 32'h8000_0000);
    check_eq("add_ovf_zero", {ovf_o, zero_o}, 2'b10);

    run_op(ALU_MULT, 32'hFFFF_FFFD, 32'h5);
    check_eq("mult_lat", lat, 33);
    check_eq("mult_busy", busy_cnt, 32);
    check_eq("mult_busy_at_done", busy_o, 0);
    check_eq("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    check_eq("mult_flags_hold", {ovf_o, zero_o, div0_o}, 3'b100);
    check_eq("mult_res_hold", result_o, 32'h8000_0000);

    run_op(ALU_MULTU, 32'hFFFF_FFFD, 32'h5);
    check_eq("multu_lat", lat, 33);
    check_eq("multu_hilo", {hi_o, lo_o}, 64'h0000_0004_FFFF_FFF1);

`ifdef MDU_DIV_EN
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'h2);
    check_eq("div_lat", lat, 33);
    check_eq("div_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    check_eq("div_div0", div0_o, 0);
    run_op(ALU_DIVU, 32'd100, 32'h0);
    check_eq("divu0_lat", lat, 33);
    check_eq("divu0_hilo", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);
    check_eq("divu0_div0", div0_o, 1);
    run_op(ALU_DIVU, 32'd100, 32'd7);
    check_eq("divu_hilo", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
    check_eq("divu_div0_clr", div0_o, 0);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_min_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
    check_eq("div_min_div0", div0_o, 0);
    exp_hi = 32'h0;
    exp_lo = 32'h8000_0000;
    rst_op = ALU_DIVU;
`else
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'h2);
    check_eq("div_nodiv_lat", lat, 1);
    check_eq("div_nodiv_busy", busy_cnt, 0);
    check_eq("div_nodiv_div0", div0_o, 1);
    check_eq("div_nodiv_hilo", {hi_o, lo_o}, 64'h0000_0004_FFFF_FFF1);
    run_op(ALU_MULTU, 32'h3, 32'h4);
    check_eq("multu_small_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_000C);
    check_eq("multu_div0_clr", div0_o, 0);
    exp_hi = 32'h0;
    exp_lo = 32'hC;
    rst_op = ALU_MULTU;
`endif

    // Flush an in-flight MULT at N+10, then issue ADD at N+12
    @(posedge clk); #1;
    start_i = 1'b1; op_i = ALU_MULT; a_i = 32'd7; b_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check_eq("flush_busy_before", busy_o, 1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check_eq("flush_busy_after", busy_o, 0);
    check_eq("flush_done_after", done_o, 0);
    run_op(ALU_ADD, 32'd2, 32'd3);
    check_eq("post_flush_add_lat", lat, 1);
    check_eq("post_flush_add_res", result_o, 5);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    check_eq("flush_no_done", pulses, 0);
    check_eq("flush_hilo_kept", {hi_o, lo_o}, {exp_hi, exp_lo});

    // start together with flush in IDLE is dropped
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = ALU_ADD; a_i = 32'd1; b_i = 32'd1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("startflush_done", done_o, 0);
    @(posedge clk); #1;
    check_eq("startflush_idle", {done_o, busy_o}, 2'b00);
    check_eq("startflush_res", result_o, 5);

    // Async reset in the middle of an op
    @(posedge clk); #1;
    start_i = 1'b1; op_i = rst_op; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midop_busy", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy_done", {busy_o, done_o}, 2'b00);
    check_eq("arst_result", result_o, 0);
    check_eq("arst_hilo", {hi_o, lo_o}, 0);
    check_eq("arst_flags", {zero_o, ovf_o, div0_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(ALU_ADD, 32'd1, 32'd2);
    check_eq("post_rst_add_lat", lat, 1);
    check_eq("post_rst_add_res", result_o, 3);
    check_eq("post_rst_hilo", {hi_o, lo_o}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
